// File: rtl/rv3n_muldiv_arbiter.sv
// Shares one iterative mul/div unit between two issue lanes with round-robin grant and tag return.
// Latency: issue the cycle after a slot loads; resp_valid the cycle after the unit's ack.
// Backpressure: one-entry slot per lane (ready = slot empty, low during flush); resp held until resp_ready.
// Optional zero-operand fast path is enabled by defining RV3N_MD_FASTPATH_EN.
module rv3n_muldiv_arbiter #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             lane0_req_valid,
  output logic             lane0_req_ready,
  input  logic [7:0]       lane0_req_para,
  input  logic [XLEN-1:0]  lane0_req_operand0,
  input  logic [XLEN-1:0]  lane0_req_operand1,
  input  logic [TAG_W-1:0] lane0_req_tag,
  input  logic             lane1_req_valid,
  output logic             lane1_req_ready,
  input  logic [7:0]       lane1_req_para,
  input  logic [XLEN-1:0]  lane1_req_operand0,
  input  logic [XLEN-1:0]  lane1_req_operand1,
  input  logic [TAG_W-1:0] lane1_req_tag,
  input  logic             flush,
  output logic             md_req_valid,
  output logic [7:0]       md_req_para,
  output logic [XLEN-1:0]  md_req_operand0,
  output logic [XLEN-1:0]  md_req_operand1,
  input  logic             md_ack_valid,
  input  logic [XLEN-1:0]  md_ack_data,
  input  logic             md_ack_busy,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_lane,
  output logic [TAG_W-1:0] resp_tag,
  output logic [XLEN-1:0]  resp_data,
  output logic             busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_DRAIN} state_t;

  state_t state, next_state;

  // Lane inputs gathered into arrays so both slots share one description
  logic [1:0]       in_vld;
  logic [7:0]       in_para [2];
  logic [XLEN-1:0]  in_op0  [2];
  logic [XLEN-1:0]  in_op1  [2];
  logic [TAG_W-1:0] in_tag  [2];

  assign in_vld     = {lane1_req_valid, lane0_req_valid};
  assign in_para[0] = lane0_req_para;
  assign in_para[1] = lane1_req_para;
  assign in_op0[0]  = lane0_req_operand0;
  assign in_op0[1]  = lane1_req_operand0;
  assign in_op1[0]  = lane0_req_operand1;
  assign in_op1[1]  = lane1_req_operand1;
  assign in_tag[0]  = lane0_req_tag;
  assign in_tag[1]  = lane1_req_tag;

  logic [1:0]       slot_vld;
  logic [7:0]       slot_para [2];
  logic [XLEN-1:0]  slot_op0  [2];
  logic [XLEN-1:0]  slot_op1  [2];
  logic [TAG_W-1:0] slot_tag  [2];
  logic             last_grant;

  // A flush must not let a new request slip into a slot it is clearing
  logic [1:0] req_rdy;
  logic [1:0] accept;
  assign req_rdy         = ~slot_vld & {2{~flush}};
  assign accept          = in_vld & req_rdy;
  assign lane0_req_ready = req_rdy[0];
  assign lane1_req_ready = req_rdy[1];

  // Round-robin: on a tie the lane that did not win last time goes next
  logic             grant_any;
  logic             grant_lane;
  logic [7:0]       g_para;
  logic [XLEN-1:0]  g_op0;
  logic [XLEN-1:0]  g_op1;
  logic [TAG_W-1:0] g_tag;
  logic             idle_go;
  logic             do_issue;
  logic             do_fast;
  logic             take;
  logic [XLEN-1:0]  fast_data;

  assign grant_any  = |slot_vld;
  assign grant_lane = (&slot_vld) ? ~last_grant : slot_vld[1];
  assign g_para     = slot_para[grant_lane];
  assign g_op0      = slot_op0[grant_lane];
  assign g_op1      = slot_op1[grant_lane];
  assign g_tag      = slot_tag[grant_lane];
  assign idle_go    = (state == ST_IDLE) && grant_any && !flush;

`ifdef RV3N_MD_FASTPATH_EN
  logic fast_hit;
  assign fast_hit = (g_op0 == '0) || (g_op1 == '0);
  assign do_fast  = idle_go && fast_hit;
  assign do_issue = idle_go && !fast_hit && !md_ack_busy;

  // Zero-operand result: mul gives 0, div by 0 all ones, rem by 0 the dividend, 0 dividend gives 0
  always_comb begin
    fast_data = '0;
    if (g_para[2] && (g_op1 == '0)) fast_data = g_para[1] ? g_op0 : '1;
  end
`else
  assign do_fast   = 1'b0;
  assign fast_data = '0;
  assign do_issue  = idle_go && !md_ack_busy;
`endif

  assign take = do_issue || do_fast;

  // Slot occupancy: load on handshake, free when granted, wipe on flush
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (flush)                                   slot_vld[i] <= 1'b0;
        else if (accept[i])                          slot_vld[i] <= 1'b1;
        else if (take && (grant_lane == 1'(i)))      slot_vld[i] <= 1'b0;
      end
    end
  end

  // Slot payload only matters while the slot is valid, so it carries no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (accept[i]) begin
        slot_para[i] <= in_para[i];
        slot_op0[i]  <= in_op0[i];
        slot_op1[i]  <= in_op1[i];
        slot_tag[i]  <= in_tag[i];
      end
    end
  end

  // Grant history; starts at 1 so lane 0 wins the first tie
  always_ff @(posedge clk) begin
    if (rst)       last_grant <= 1'b1;
    else if (take) last_grant <= grant_lane;
  end

  // Response register: owner latched at grant, data from fast path or unit ack
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_lane <= 1'b0;
      resp_tag  <= '0;
      resp_data <= '0;
    end else begin
      if (take) begin
        resp_lane <= grant_lane;
        resp_tag  <= g_tag;
      end
      if (do_fast)                                              resp_data <= fast_data;
      else if ((state == ST_WAIT) && md_ack_valid && !flush)    resp_data <= md_ack_data;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // Next state; the unit cannot be aborted so a flushed op is drained unless its ack is already here
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (do_issue)     next_state = ST_WAIT;
                else if (do_fast) next_state = ST_RESP;
      ST_WAIT:  if (flush)        next_state = md_ack_valid ? ST_IDLE : ST_DRAIN;
                else if (md_ack_valid) next_state = ST_RESP;
      ST_RESP:  if (flush || resp_ready) next_state = ST_IDLE;
      ST_DRAIN: if (md_ack_valid) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // Outputs; unit request fields read as zero when no issue is happening
  always_comb begin
    md_req_valid    = do_issue;
    md_req_para     = '0;
    md_req_operand0 = '0;
    md_req_operand1 = '0;
    if (do_issue) begin
      md_req_para     = g_para;
      md_req_operand0 = g_op0;
      md_req_operand1 = g_op1;
    end
    resp_valid = (state == ST_RESP);
    busy       = (state != ST_IDLE) || (|slot_vld);
  end

endmodule

// File: tb/tb_rv3n_muldiv_arbiter.sv
// Self-checking bench for rv3n_muldiv_arbiter: directed vector table, corner sequences, randomized scoreboard.
// Contains a cycle-counted model of the iterative unit that answers every issue after unit_lat cycles.
// Expectations for zero-operand ops follow RV3N_MD_FASTPATH_EN when defined.
module tb_rv3n_muldiv_arbiter;
  localparam int XLEN  = 32;
  localparam int TAG_W = 4;
`ifdef RV3N_MD_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             lane0_req_valid = 0, lane1_req_valid = 0;
  logic             lane0_req_ready, lane1_req_ready;
  logic [7:0]       lane0_req_para = 0, lane1_req_para = 0;
  logic [XLEN-1:0]  lane0_req_operand0 = 0, lane0_req_operand1 = 0;
  logic [XLEN-1:0]  lane1_req_operand0 = 0, lane1_req_operand1 = 0;
  logic [TAG_W-1:0] lane0_req_tag = 0, lane1_req_tag = 0;
  logic             flush = 0;
  logic             md_req_valid;
  logic [7:0]       md_req_para;
  logic [XLEN-1:0]  md_req_operand0, md_req_operand1;
  logic             md_ack_valid = 0;
  logic [XLEN-1:0]  md_ack_data = 0;
  logic             md_ack_busy;
  logic             resp_valid;
  logic             resp_ready = 1;
  logic             resp_lane;
  logic [TAG_W-1:0] resp_tag;
  logic [XLEN-1:0]  resp_data;
  logic             busy;

  logic unit_busy = 0;
  logic hold_busy = 0;
  assign md_ack_busy = unit_busy | hold_busy;

  rv3n_muldiv_arbiter #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .lane0_req_valid(lane0_req_valid), .lane0_req_ready(lane0_req_ready), .lane0_req_para(lane0_req_para),
    .lane0_req_operand0(lane0_req_operand0), .lane0_req_operand1(lane0_req_operand1), .lane0_req_tag(lane0_req_tag),
    .lane1_req_valid(lane1_req_valid), .lane1_req_ready(lane1_req_ready), .lane1_req_para(lane1_req_para),
    .lane1_req_operand0(lane1_req_operand0), .lane1_req_operand1(lane1_req_operand1), .lane1_req_tag(lane1_req_tag),
    .flush(flush),
    .md_req_valid(md_req_valid), .md_req_para(md_req_para),
    .md_req_operand0(md_req_operand0), .md_req_operand1(md_req_operand1),
    .md_ack_valid(md_ack_valid), .md_ack_data(md_ack_data), .md_ack_busy(md_ack_busy),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_lane(resp_lane),
    .resp_tag(resp_tag), .resp_data(resp_data), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Architectural result of an op, unsigned; used by the unit model and the scoreboard
  function automatic logic [31:0] ref_calc(input logic [7:0] p, input logic [31:0] a, input logic [31:0] b);
    if (!p[2])  return a * b;
    if (b == 0) return p[1] ? a : 32'hFFFF_FFFF;
    return p[1] ? (a % b) : (a / b);
  endfunction

  typedef struct packed {logic [7:0] para; logic [31:0] a; logic [31:0] b; logic [3:0] tag;} req_t;
  typedef struct packed {logic lane; logic [3:0] tag; logic [31:0] data;} rsp_t;

  // Monitor state
  int          issue_cnt = 0, resp_cnt = 0, rv_cnt = 0;
  int          acc_cnt0 = 0, acc_cnt1 = 0;
  logic [31:0] last_res = 0;
  logic [31:0] issue_log[$];
  bit          outstanding = 0;
  bit          mon_en = 0;
  bit          prev_hold = 0;
  bit          ack_prev = 0;
  logic [63:0] hold_snap = 0;
  req_t        mq0[$], mq1[$];
  rsp_t        eq[$];
  bit          m_last = 1;

  // Unit model: starts on a new issue, answers unit_lat cycles later
  int unit_lat = 2;
  int u_cnt = 0;
  int u_seen = 0;
  always @(posedge clk) begin
    #1;
    md_ack_valid = 0;
    if (rst) begin
      u_cnt = 0; u_seen = issue_cnt; unit_busy = 0;
    end else if (u_cnt > 0) begin
      u_cnt--;
      if (u_cnt == 0) begin md_ack_valid = 1; md_ack_data = last_res; unit_busy = 0; end
    end else if (issue_cnt != u_seen) begin
      u_seen = issue_cnt; unit_busy = 1; u_cnt = unit_lat;
    end
  end

  task automatic model_issue();
    req_t r;
    bit   ln;
    if (mq0.size() == 0 && mq1.size() == 0) begin
      check("rand_issue_unexpected", 64'(1), 64'(0));
    end else begin
      ln = (mq0.size() > 0 && mq1.size() > 0) ? !m_last : (mq1.size() > 0);
      r  = ln ? mq1.pop_front() : mq0.pop_front();
      check("rand_issue_para_op1", 64'({md_req_para, md_req_operand1}), 64'({r.para, r.b}));
      check("rand_issue_op0", 64'(md_req_operand0), 64'(r.a));
      m_last = ln;
      eq.push_back('{lane: ln, tag: r.tag, data: ref_calc(r.para, r.a, r.b)});
    end
  endtask

  task automatic model_resp();
    rsp_t r;
    if (eq.size() == 0) begin
      check("rand_resp_unexpected", 64'(1), 64'(0));
    end else begin
      r = eq.pop_front();
      check("rand_resp", 64'({resp_lane, resp_tag, resp_data}), 64'(r));
    end
  endtask

  // Observe mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      outstanding = 0; prev_hold = 0; ack_prev = 0;
    end else begin
      if (md_ack_valid) outstanding = 0;
      if (mon_en && ack_prev) check("resp_after_ack", 64'(resp_valid), 64'(1));
      ack_prev = md_ack_valid;
      if (md_req_valid) begin
        check("one_in_flight", 64'(outstanding), 64'(0));
        outstanding = 1;
        issue_cnt++;
        last_res = ref_calc(md_req_para, md_req_operand0, md_req_operand1);
        issue_log.push_back(md_req_operand0);
        if (mon_en) model_issue();
      end
      if (resp_valid) rv_cnt++;
      if (mon_en) begin
        if (prev_hold) check("resp_stable", 64'({resp_valid, resp_lane, resp_tag, resp_data}), hold_snap);
        prev_hold = resp_valid & ~resp_ready;
        hold_snap = 64'({resp_valid, resp_lane, resp_tag, resp_data});
        if (resp_valid && resp_ready) model_resp();
        if (lane0_req_valid && lane0_req_ready) begin
          mq0.push_back('{para: lane0_req_para, a: lane0_req_operand0, b: lane0_req_operand1, tag: lane0_req_tag});
          acc_cnt0++;
        end
        if (lane1_req_valid && lane1_req_ready) begin
          mq1.push_back('{para: lane1_req_para, a: lane1_req_operand0, b: lane1_req_operand1, tag: lane1_req_tag});
          acc_cnt1++;
        end
      end else begin
        prev_hold = 0;
      end
      if (resp_valid && resp_ready) resp_cnt++;
    end
  end

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  // Present one request from posedge+1 and hold it until accepted; returns at posedge+1 of the following cycle
  task automatic drive_req(input int lane, input logic [7:0] p, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] t);
    bit ok = 0;
    if (lane == 0) begin
      lane0_req_valid = 1; lane0_req_para = p; lane0_req_operand0 = a; lane0_req_operand1 = b; lane0_req_tag = t;
    end else begin
      lane1_req_valid = 1; lane1_req_para = p; lane1_req_operand0 = a; lane1_req_operand1 = b; lane1_req_tag = t;
    end
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if ((lane == 0) ? lane0_req_ready : lane1_req_ready) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) check("req_accept_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    if (lane == 0) lane0_req_valid = 0; else lane1_req_valid = 0;
  endtask

  task automatic wait_resp(output bit ok, output int cyc);
    ok = 0; cyc = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (resp_valid) begin ok = 1; cyc = n; break; end
    end
  endtask

  typedef struct {int lane; logic [7:0] p; logic [31:0] a; logic [31:0] b; logic [3:0] tag; logic [31:0] exp; bit zero;} vec_t;
  vec_t tv[8];

  function automatic req_t rand_req();
    req_t r;
    case ($urandom_range(0, 4))
      0: r.para = 8'h00;
      1: r.para = 8'h01;
      2: r.para = 8'h05;
      3: r.para = 8'h06;
      default: r.para = 8'h07;
    endcase
    r.a = $urandom;
    if (r.a == 0) r.a = 1;
    if ($urandom_range(0, 1) == 0) r.a = $urandom_range(1, 5000);
    r.b = $urandom_range(1, 300);
    r.tag = 4'($urandom_range(0, 15));
    return r;
  endfunction

  initial begin
    bit   ok;
    int   cyc, ic, rc, base, acc_seen0, acc_seen1;
    logic [31:0] want[4];
    req_t r;

    tv[0] = '{0, 8'h00, 32'd7,        32'd6,        4'd3,  32'd42,         1'b0};
    tv[1] = '{1, 8'h05, 32'd100,      32'd7,        4'd9,  32'd14,         1'b0};
    tv[2] = '{0, 8'h07, 32'd100,      32'd7,        4'd1,  32'd2,          1'b0};
    tv[3] = '{1, 8'h05, 32'd100,      32'd0,        4'd5,  32'hFFFF_FFFF,  1'b1};
    tv[4] = '{0, 8'h07, 32'd100,      32'd0,        4'd6,  32'd100,        1'b1};
    tv[5] = '{1, 8'h00, 32'd0,        32'd5,        4'd7,  32'd0,          1'b1};
    tv[6] = '{0, 8'h05, 32'd0,        32'd9,        4'd2,  32'd0,          1'b1};
    tv[7] = '{1, 8'h00, 32'h0001_0000, 32'h0001_0001, 4'd15, 32'h0001_0000, 1'b0};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_ready", 64'({lane0_req_ready, lane1_req_ready}), 64'(2'b11));
    check("rst_md_req", 64'({md_req_valid, md_req_para, md_req_operand0}), 64'(0));
    check("rst_resp_busy", 64'({resp_valid, resp_lane, resp_tag, busy}), 64'(0));
    check("rst_resp_data", 64'(resp_data), 64'(0));
    @(posedge clk); #1;

    // Vector table: single ops with issue timing, payload and response
    foreach (tv[i]) begin
      ic = issue_cnt;
      drive_req(tv[i].lane, tv[i].p, tv[i].a, tv[i].b, tv[i].tag);
      @(negedge clk);
      if (FAST && tv[i].zero) begin
        check($sformatf("v%0d_no_issue", i), 64'(md_req_valid), 64'(0));
      end else begin
        check($sformatf("v%0d_issue_lat", i), 64'(md_req_valid), 64'(1));
        check($sformatf("v%0d_issue_ops", i), {md_req_operand0, md_req_operand1}, {tv[i].a, tv[i].b});
        check($sformatf("v%0d_issue_para", i), 64'(md_req_para), 64'(tv[i].p));
      end
      wait_resp(ok, cyc);
      check($sformatf("v%0d_resp_seen", i), 64'(ok), 64'(1));
      if (FAST && tv[i].zero) check($sformatf("v%0d_fast_lat", i), 64'(cyc), 64'(0));
      check($sformatf("v%0d_resp", i), 64'({resp_lane, resp_tag, resp_data}),
            64'({tv[i].lane[0], tv[i].tag, tv[i].exp}));
      @(posedge clk); #1;
      check($sformatf("v%0d_issues", i), 64'(issue_cnt - ic), 64'((FAST && tv[i].zero) ? 0 : 1));
    end

    // Round-robin: both lanes twice, tie after reset goes to lane 0
    do_reset();
    base = issue_log.size();
    rc = resp_cnt;
    fork
      begin drive_req(0, 8'h00, 32'd100, 32'd2, 4'd0); drive_req(0, 8'h00, 32'd101, 32'd2, 4'd1); end
      begin drive_req(1, 8'h00, 32'd110, 32'd2, 4'd2); drive_req(1, 8'h00, 32'd111, 32'd2, 4'd3); end
    join
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (resp_cnt >= rc + 4) break;
    end
    check("rr_resp_count", 64'(resp_cnt - rc), 64'(4));
    want[0] = 100; want[1] = 110; want[2] = 101; want[3] = 111;
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_order%0d", k), 64'((issue_log.size() > base + k) ? issue_log[base + k] : 32'hDEAD), 64'(want[k]));
    @(posedge clk); #1;

    // Response held under backpressure, no new issue meanwhile
    do_reset();
    resp_ready = 0;
    fork
      drive_req(0, 8'h00, 32'd3, 32'd5, 4'd4);
      drive_req(1, 8'h00, 32'd2, 32'd2, 4'd8);
    join
    wait_resp(ok, cyc);
    check("bp_resp_seen", 64'(ok), 64'(1));
    ic = issue_cnt;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", 64'({resp_valid, resp_lane, resp_tag, resp_data}), 64'({1'b1, 1'b0, 4'd4, 32'd15}));
    end
    check("bp_no_issue", 64'(issue_cnt - ic), 64'(0));
    @(posedge clk); #1 resp_ready = 1;
    @(negedge clk);
    wait_resp(ok, cyc);
    check("bp_second", 64'({ok, resp_lane, resp_tag, resp_data}), 64'({1'b1, 1'b1, 4'd8, 32'd4}));
    @(posedge clk); #1;

    // Unit busy blocks issue; slot stays occupied until it drops
    hold_busy = 1;
    drive_req(0, 8'h00, 32'd9, 32'd9, 4'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("busy_block", 64'({md_req_valid, lane0_req_ready, busy}), 64'(3'b001));
    end
    @(posedge clk); #1 hold_busy = 0;
    @(negedge clk);
    check("busy_release_issue", 64'(md_req_valid), 64'(1));
    wait_resp(ok, cyc);
    check("busy_resp", 64'({ok, resp_data}), 64'({1'b1, 32'd81}));
    @(posedge clk); #1;

    // Flush while waiting: both slots cleared, result drained, nothing returned
    do_reset();
    unit_lat = 6;
    drive_req(0, 8'h00, 32'd3, 32'd3, 4'd2);
    @(posedge clk); #1;
    drive_req(1, 8'h00, 32'd4, 32'd4, 4'd3);
    flush = 1; lane0_req_valid = 1;
    @(negedge clk);
    check("flush_ready_low", 64'({lane0_req_ready, lane1_req_ready}), 64'(0));
    @(posedge clk); #1 flush = 0; lane0_req_valid = 0;
    ic = issue_cnt; rc = rv_cnt;
    @(negedge clk);
    check("flush_slots_empty", 64'({lane0_req_ready, lane1_req_ready, busy}), 64'(3'b111));
    for (int n = 0; n < 20; n++) @(negedge clk);
    check("flush_no_resp", 64'(rv_cnt - rc), 64'(0));
    check("flush_no_issue", 64'(issue_cnt - ic), 64'(0));
    check("flush_idle", 64'(busy), 64'(0));
    @(posedge clk); #1 unit_lat = 2;
    drive_req(1, 8'h00, 32'd5, 32'd5, 4'd4);
    wait_resp(ok, cyc);
    check("flush_after", 64'({ok, resp_lane, resp_tag, resp_data}), 64'({1'b1, 1'b1, 4'd4, 32'd25}));
    @(posedge clk); #1;

    // Flush coinciding with the ack: result dropped, back to idle
    unit_lat = 3;
    drive_req(0, 8'h00, 32'd6, 32'd6, 4'd5);
    ok = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #2;
      if (md_ack_valid) begin flush = 1; ok = 1; break; end
    end
    check("ackflush_ack_seen", 64'(ok), 64'(1));
    rc = rv_cnt;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    check("ackflush_idle", 64'({resp_valid, busy}), 64'(0));
    for (int n = 0; n < 5; n++) @(negedge clk);
    check("ackflush_no_resp", 64'(rv_cnt - rc), 64'(0));
    @(posedge clk); #1;

    // Randomized traffic against the scoreboard
    do_reset();
    mq0.delete(); mq1.delete(); eq.delete();
    m_last = 1;
    mon_en = 1;
    acc_seen0 = acc_cnt0; acc_seen1 = acc_cnt1;
    for (int c = 0; c < 900; c++) begin
      @(posedge clk); #1;
      unit_lat = $urandom_range(1, 4);
      resp_ready = ($urandom_range(0, 3) != 0);
      if (acc_cnt0 != acc_seen0 || !lane0_req_valid) begin
        acc_seen0 = acc_cnt0;
        if (c < 800 && $urandom_range(0, 2) == 0) begin
          r = rand_req();
          lane0_req_valid = 1; lane0_req_para = r.para; lane0_req_operand0 = r.a;
          lane0_req_operand1 = r.b; lane0_req_tag = r.tag;
        end else lane0_req_valid = 0;
      end
      if (acc_cnt1 != acc_seen1 || !lane1_req_valid) begin
        acc_seen1 = acc_cnt1;
        if (c < 800 && $urandom_range(0, 2) == 0) begin
          r = rand_req();
          lane1_req_valid = 1; lane1_req_para = r.para; lane1_req_operand0 = r.a;
          lane1_req_operand1 = r.b; lane1_req_tag = r.tag;
        end else lane1_req_valid = 0;
      end
    end
    lane0_req_valid = 0; lane1_req_valid = 0; resp_ready = 1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (!busy && eq.size() == 0 && !outstanding) break;
    end
    check("rand_drained", 64'({busy, outstanding}), 64'(0));
    check("rand_queues_empty", 64'(eq.size() + mq0.size() + mq1.size()), 64'(0));
    mon_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv3n_muldiv_arbiter.md
# rv3n_muldiv_arbiter

Shares the single iterative multiply/divide unit between two issue lanes. Each lane has a one-entry request slot; a round-robin scheduler issues one operation at a time to the unit, waits for its acknowledge, and returns the result with the requester's lane and tag on one shared response port. A pipeline flush discards all queued and in-flight work; the unit cannot be aborted, so an in-flight result is drained and dropped.

## Interface
- XLEN, 32, operand and result width
- TAG_W, 4, requester tag width (destination register / ROB id)

- clk  in  1  clock
- rst  in  1  reset (one clock; synchronous, active-high)
- lane0_req_valid / lane1_req_valid  in  1  request present
- lane0_req_ready / lane1_req_ready  out  1  slot empty, request accepted on valid&ready
- laneN_req_para  in  8  op code: [2]=div, [1]/[0] select variant; passed through unchanged
- laneN_req_operand0 / laneN_req_operand1  in  XLEN  rs1 / rs2
- laneN_req_tag  in  TAG_W  returned with result
- flush  in  1  discard all pending and in-flight operations
- md_req_valid  out  1  issue pulse to unit
- md_req_para  out  8; md_req_operand0 / md_req_operand1  out  XLEN  (unit imm/pc inputs tied to 0 at instantiation)
- md_ack_valid  in  1; md_ack_data  in  XLEN; md_ack_busy  in  1  unit handshake
- resp_valid  out  1; resp_ready  in  1; resp_lane  out  1; resp_tag  out  TAG_W; resp_data  out  XLEN
- busy  out  1  state != IDLE or any slot valid

## Operation
- Slots: slotN_valid set on laneN_req_valid & laneN_req_ready; laneN_req_ready = ~slotN_valid. Cleared when its operation is issued (or fast-resolved).
- Arbitration in IDLE: one valid slot → grant it; both valid → grant lane != last_grant. last_grant updates on each grant; reset value 1 (lane 0 wins first tie).
- States: IDLE, WAIT, RESP, DRAIN.
  - IDLE: granted slot and ~md_ack_busy → md_req_valid=1 this cycle with slot's para/operands; latch lane, tag; clear slot; → WAIT.
  - WAIT: md_ack_valid → capture md_ack_data into resp register → RESP.
  - RESP: resp_valid=1; resp_valid & resp_ready → IDLE.
  - DRAIN: wait md_ack_valid, drop data → IDLE.
- Flush: clears both slots same edge. WAIT → DRAIN; RESP → IDLE (response dropped); IDLE issue suppressed that cycle. flush in DRAIN has no extra effect.
- Simultaneous flush and laneN_req_valid: request is not accepted (ready forced 0 while flush=1).
- Simultaneous md_ack_valid and flush in WAIT: result dropped, → IDLE.
- md_req_* outputs 0 whenever md_req_valid=0.

## Timing
- Reset: all slots empty, state IDLE, last_grant=1; all outputs 0 except laneN_req_ready=1.
- Request accepted cycle A → issue at A+1 earliest; resp_valid first cycle after md_ack_valid.
- One operation in flight; responses in issue order; resp_* held stable while resp_valid & ~resp_ready.
- New slot may be loaded the cycle after its previous contents issue.

## Configuration
- RV3N_MD_FASTPATH_EN defined: in IDLE, a granted op with operand1==0 or operand0==0 is resolved without issuing: mul → 0; div (para[2]=1,para[1]=0) by 0 → all ones; rem (para[2]=1,para[1]=1) by 0 → operand0; div/rem with operand0==0, operand1!=0 → 0. Result loaded to resp register, slot cleared, → RESP next cycle (resp_valid at A+2). Allowed even while md_ack_busy.
- Undefined: every operation issues to the unit; no zero detection logic.

## Test plan
- Lane0 mul 7×6, tag 3 → one md_req_valid pulse with operands 7/6; after md_ack_valid data 42, resp_valid with lane 0, tag 3, data 42.
- Both lanes request same cycle, then both again → grant order lane0, lane1, lane0, lane1; exactly one op outstanding.
- resp_ready held low 5 cycles → resp stable, no new md_req_valid until accepted.
- Flush during WAIT → slots cleared, ack dropped, no resp_valid; next request processed normally.
- Flush in the cycle md_ack_valid arrives → no response; state IDLE next cycle.
- With RV3N_MD_FASTPATH_EN: divu 100/0 → resp 0xFFFFFFFF, remu 100/0 → 100, mul 0×5 → 0, none produce md_req_valid; without macro each issues to unit.
